l2c_tag_arb: RTL and testbench
==============================

L2C_TAG_ARB -- requirements
Module: l2c_tag_arb

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, which sets the number of tag-pipeline requesters (2..8).
REQ-002 The module SHALL have parameter WDOG_MAX, default 255, which sets the Grant-state cycle count that raises the watchdog error.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port i_req, input, N_REQ bits: per-requester tag access request, level, held until its ack.
REQ-006 The module SHALL have port i_tag_ack, input, 1 bit: the tag pipeline has accepted and completed the granted access.
REQ-007 The module SHALL have port o_tag_req, output, 1 bit: request to the tag pipeline.
REQ-008 The module SHALL have port o_gnt, output, N_REQ bits: one-hot owner of the current tag access.
REQ-009 The module SHALL have port o_ack, output, N_REQ bits: one-cycle completion pulse to the granted requester.
REQ-010 The module SHALL have port o_busy, output, 1 bit: asserted in any state other than Idle.
REQ-011 The module SHALL have port o_wdog_err, output, 1 bit: sticky watchdog error.

Function
REQ-012 The FSM SHALL be one-hot with exactly three states: Idle, Grant, Done.
REQ-013 Idle: with any i_req bit set, the FSM SHALL register the round-robin winner into the grant register and move to Grant; otherwise it SHALL stay in Idle.
REQ-014 The round-robin winner SHALL be the first set i_req bit at or above pointer ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-015 Grant: o_tag_req=1 and o_gnt=grant register; on i_tag_ack=1 the FSM SHALL move to Done, otherwise stay in Grant.
REQ-016 Done: o_ack SHALL equal the grant register for exactly that one cycle; ptr SHALL update to winner+1 modulo N_REQ; the FSM SHALL then return to Idle.
REQ-017 Latency: i_req rising in Idle at cycle t SHALL give o_tag_req=1 at t+1; i_tag_ack at cycle t SHALL give o_ack at t+1; minimum service is 3 cycles per access.
REQ-018 o_gnt SHALL be 0 in Idle and Done, and SHALL NOT change while in Grant.
REQ-019 A requester deasserting i_req during Grant SHALL NOT abort the access; it SHALL still receive o_ack.
REQ-020 i_tag_ack outside Grant SHALL be ignored.
REQ-021 A requester that stays asserted SHALL NOT be granted twice in a row while any other i_req bit is set (no starvation).
REQ-022 The ptr update to winner+1 SHALL wrap to 0 when winner is N_REQ-1.

Reset
REQ-023 While Reset=0, the FSM SHALL be held in Idle and ptr SHALL be 0.
REQ-024 While Reset=0, the grant register SHALL be 0, o_tag_req=0, o_gnt=0, o_ack=0, o_busy=0 and o_wdog_err=0.
REQ-025 Reset asserted mid-Grant SHALL drop the access with no o_ack pulse.
REQ-026 The first grant after reset deassertion SHALL follow the normal Idle rules.

Configuration
REQ-027 With macro L2C_TAG_ARB_WDOG_EN defined, a counter SHALL clear on entry to Grant and increment each cycle in Grant.
REQ-028 With L2C_TAG_ARB_WDOG_EN defined, reaching WDOG_MAX SHALL set o_wdog_err, which SHALL stay set until reset; the FSM SHALL remain in Grant until i_tag_ack.
REQ-029 Without L2C_TAG_ARB_WDOG_EN, no counter SHALL exist and o_wdog_err SHALL be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: after reset, i_req=4'b0100 at cycle 0 and i_tag_ack at cycle 3 -> o_gnt=0100 and o_tag_req=1 in cycles 1-3, o_ack=0100 in cycle 4 only, Idle in cycle 5, ptr=3.
REQ-031 Scenario: i_req=4'b1111 held, i_tag_ack on the first Grant cycle each time -> grants in order 0001, 0010, 0100, 1000, 0001, with 3-cycle spacing.
REQ-032 Scenario: ptr=3 and i_req=4'b0011 -> wrap-around grants requester 0 first, then requester 1.
REQ-033 Scenario: i_req dropped one cycle after grant with i_tag_ack 2 cycles later -> o_ack still pulses to that requester; a stray i_tag_ack in Idle -> no state change.
REQ-034 Scenario: Reset=0 asserted mid-Grant -> all outputs 0 asynchronously, no o_ack pulse.
REQ-035 Scenario: with L2C_TAG_ARB_WDOG_EN and WDOG_MAX=8, no i_tag_ack -> o_wdog_err rises after 8 Grant cycles and stays 1 after a later ack; without the macro, o_wdog_err stays 0.

Source files
------------

// File: rtl/l2c_tag_arb.sv
// Round-robin arbiter for L2 cache tag-pipeline access (one-hot Idle/Grant/Done FSM).
// Optional watchdog on Grant duration enabled by defining L2C_TAG_ARB_WDOG_EN.
module l2c_tag_arb #(
  parameter int N_REQ    = 4,
  parameter int WDOG_MAX = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_tag_ack,
  output logic             o_tag_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [N_REQ-1:0] o_ack,
  output logic             o_busy,
  output logic             o_wdog_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_GRANT = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b100;

  if (N_REQ < 2 || N_REQ > 8 || WDOG_MAX < 1) begin : g_param_check
    $error("l2c_tag_arb: N_REQ must be 2..8 and WDOG_MAX at least 1");
  end

  logic [2:0]       state, state_nxt;
  logic [PW-1:0]    ptr, gnt_idx, win_idx;
  logic [N_REQ-1:0] gnt_reg, win_oh;
  logic             win_vld;
  logic [PW:0]      cand;

  // Search upward from ptr with wrap; the first set request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ))
        cand = cand - (PW+1)'(N_REQ);
      if (!win_vld && i_req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
    win_oh[win_idx] = win_vld;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld)   state_nxt = S_GRANT;
      S_GRANT: if (i_tag_ack) state_nxt = S_DONE;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr     <= '0;
      gnt_idx <= '0;
      gnt_reg <= '0;
    end else if (state == S_IDLE && win_vld) begin
      gnt_idx <= win_idx;
      gnt_reg <= win_oh;
    end else if (state == S_DONE) begin
      ptr <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign o_tag_req = (state == S_GRANT);
  assign o_gnt     = o_tag_req ? gnt_reg : '0;
  assign o_ack     = (state == S_DONE) ? gnt_reg : '0;
  assign o_busy    = (state != S_IDLE);

`ifdef L2C_TAG_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_MAX + 1);

  logic [CW-1:0] wdog_cnt;
  logic          wdog_err;

  // Counter saturates at WDOG_MAX; the error flag is sticky until reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else if (state == S_IDLE && win_vld) begin
      wdog_cnt <= '0;
    end else if (state == S_GRANT) begin
      if (wdog_cnt != CW'(WDOG_MAX))
        wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt == CW'(WDOG_MAX-1))
        wdog_err <= 1'b1;
    end
  end

  assign o_wdog_err = wdog_err;
`else
  assign o_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_l2c_tag_arb.sv
// Directed, table-driven bench for l2c_tag_arb (N_REQ=4, WDOG_MAX=8).
module tb_l2c_tag_arb;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] i_req;
  logic       i_tag_ack;
  logic       o_tag_req;
  logic [3:0] o_gnt;
  logic [3:0] o_ack;
  logic       o_busy;
  logic       o_wdog_err;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  l2c_tag_arb #(.N_REQ(4), .WDOG_MAX(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_req      (i_req),
    .i_tag_ack  (i_tag_ack),
    .o_tag_req  (o_tag_req),
    .o_gnt      (o_gnt),
    .o_ack      (o_ack),
    .o_busy     (o_busy),
    .o_wdog_err (o_wdog_err)
  );

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       tq;
    logic [3:0] gnt;
    logic [3:0] ak;
    logic       busy;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    i_req     = '0;
    i_tag_ack = 1'b0;
    step();
    step();
    chk("rst tag_req", {7'b0, o_tag_req}, 8'h0);
    chk("rst gnt", {4'b0, o_gnt}, 8'h0);
    chk("rst ack", {4'b0, o_ack}, 8'h0);
    chk("rst busy", {7'b0, o_busy}, 8'h0);
    chk("rst wdog", {7'b0, o_wdog_err}, 8'h0);
    Reset = 1'b1;
  endtask

  initial begin
    logic [3:0] e;
    logic       wexp;

    // req, ack | tag_req, gnt, ack, busy  (outputs seen in the same row's cycle)
    vecs[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1};
    vecs[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[10] = '{4'b0011, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[13] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1};
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1};
    vecs[16] = '{4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1};
    vecs[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1};
    vecs[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};

    do_reset();

    // Single access, stray ack in Idle, wrap from ptr=3, drop of request during Grant.
    for (int r = 0; r < 19; r++) begin
      i_req     = vecs[r].req;
      i_tag_ack = vecs[r].ack;
      chk($sformatf("row%0d tag_req", r), {7'b0, o_tag_req}, {7'b0, vecs[r].tq});
      chk($sformatf("row%0d gnt", r), {4'b0, o_gnt}, {4'b0, vecs[r].gnt});
      chk($sformatf("row%0d ack", r), {4'b0, o_ack}, {4'b0, vecs[r].ak});
      chk($sformatf("row%0d busy", r), {7'b0, o_busy}, {7'b0, vecs[r].busy});
      step();
    end

    // All requesters held: rotation 0,1,2,3,0 with 3-cycle spacing.
    do_reset();
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      chk($sformatf("rr%0d idle busy", k), {7'b0, o_busy}, 8'h0);
      step();
      chk($sformatf("rr%0d gnt", k), {4'b0, o_gnt}, {4'b0, e});
      i_tag_ack = 1'b1;
      step();
      i_tag_ack = 1'b0;
      chk($sformatf("rr%0d ack", k), {4'b0, o_ack}, {4'b0, e});
      step();
    end

    // Reset asserted mid-Grant clears outputs immediately and suppresses the ack.
    do_reset();
    i_req = 4'b0110;
    step();
    chk("mid gnt before", {4'b0, o_gnt}, 8'h02);
    #2 Reset = 1'b0;
    #1;
    chk("mid rst tag_req", {7'b0, o_tag_req}, 8'h0);
    chk("mid rst gnt", {4'b0, o_gnt}, 8'h0);
    chk("mid rst busy", {7'b0, o_busy}, 8'h0);
    i_tag_ack = 1'b1;
    step();
    chk("mid rst ack", {4'b0, o_ack}, 8'h0);
    #1 Reset = 1'b1;
    i_tag_ack = 1'b0;
    chk("post rst ack", {4'b0, o_ack}, 8'h0);
    chk("post rst busy", {7'b0, o_busy}, 8'h0);
    step();
    chk("post rst gnt", {4'b0, o_gnt}, 8'h02);
    i_tag_ack = 1'b1;
    step();
    i_tag_ack = 1'b0;
    i_req     = 4'b0001;
    chk("post rst done ack", {4'b0, o_ack}, 8'h02);
    step();

    // Long Grant without ack: watchdog only when the feature is built in.
    step();
    i_req = 4'b0000;
    for (int g = 1; g <= 12; g++) begin
`ifdef L2C_TAG_ARB_WDOG_EN
      wexp = (g >= 9);
`else
      wexp = 1'b0;
`endif
      chk($sformatf("wd g%0d err", g), {7'b0, o_wdog_err}, {7'b0, wexp});
      chk($sformatf("wd g%0d gnt", g), {4'b0, o_gnt}, 8'h01);
      step();
    end
    i_tag_ack = 1'b1;
    step();
    i_tag_ack = 1'b0;
    chk("wd ack", {4'b0, o_ack}, 8'h01);
    step();
`ifdef L2C_TAG_ARB_WDOG_EN
    wexp = 1'b1;
`else
    wexp = 1'b0;
`endif
    chk("wd sticky err", {7'b0, o_wdog_err}, {7'b0, wexp});
    chk("wd idle busy", {7'b0, o_busy}, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
